// File: rtl/io_port_responder_pkg.sv
// Shared constants for the memory-mapped I/O responder: address map, FSM codes, bus payload.
// Optional feature macro: IO_RESP_IRQ_EN (IRQ_MASK register and change interrupt).
package io_port_responder_pkg;

   localparam int unsigned DATA_W    = 32;
   localparam int unsigned ADDR_W    = 8;
   localparam int unsigned CNT_W     = 4;
   localparam int unsigned NUM_PORTS = 3;

   // Byte addresses of the mapped registers (addr[1:0] are ignored by the decoder)
   localparam logic [ADDR_W-1:0] IO_OUT0     = 8'h80;
   localparam logic [ADDR_W-1:0] IO_OUT1     = 8'h84;
   localparam logic [ADDR_W-1:0] IO_OUT2     = 8'h88;
   localparam logic [ADDR_W-1:0] IO_IN0      = 8'hC0;
   localparam logic [ADDR_W-1:0] IO_IN1      = 8'hC4;
   localparam logic [ADDR_W-1:0] IO_IN2      = 8'hC8;
   localparam logic [ADDR_W-1:0] IO_STATUS   = 8'hCC;
   localparam logic [ADDR_W-1:0] IO_IRQ_MASK = 8'hD0;

   // Handshake FSM state codes
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   // One bus access as presented by the MEM stage
   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } io_req_t;

   // Word index used by the decoder
   function automatic logic [ADDR_W-3:0] io_word(input logic [ADDR_W-1:0] a);
      return a[ADDR_W-1:2];
   endfunction

endpackage

// File: rtl/io_in_sync.sv
// Input-port synchronizer: SYNC_STAGES flop chain, a 'prev' register, and a change indication.
module io_in_sync #(
   parameter int unsigned IN_W        = 4,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic            i_clock,
   input  logic            i_reset,
   input  logic [IN_W-1:0] i_async,
   output logic [IN_W-1:0] o_synced,
   output logic            o_change_c
);

   logic [IN_W-1:0] r_chain [SYNC_STAGES];
   logic [IN_W-1:0] r_prev;

   // Shift the asynchronous value through the chain and remember the last synced value
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
            r_chain[s] <= '0;
         end
         r_prev <= '0;
      end else begin
         r_chain[0] <= i_async;
         for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
            r_chain[s] <= r_chain[s-1];
         end
         r_prev <= r_chain[SYNC_STAGES-1];
      end
   end

   assign o_synced   = r_chain[SYNC_STAGES-1];
   assign o_change_c = (r_chain[SYNC_STAGES-1] != r_prev);

endmodule

// File: rtl/io_port_responder.sv
// MEM-stage I/O responder: output port registers, synchronized input ports, sticky change flags,
// req/ack handshake with WAIT_CYCLES wait states. Optional macro IO_RESP_IRQ_EN adds IRQ_MASK and irq.
module io_port_responder
   import io_port_responder_pkg::*;
#(
   parameter int unsigned WAIT_CYCLES = 1,
   parameter int unsigned IN_W        = 4,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic              i_clock,
   input  logic              i_reset,
   input  logic              i_req,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [DATA_W-1:0] i_wdata,
   output logic [DATA_W-1:0] o_rdata,
   output logic              o_ack,
   input  logic [IN_W-1:0]   i_in_port0,
   input  logic [IN_W-1:0]   i_in_port1,
   input  logic [IN_W-1:0]   i_in_port2,
   output logic [DATA_W-1:0] o_out_port0,
   output logic [DATA_W-1:0] o_out_port1,
   output logic [DATA_W-1:0] o_out_port2,
   output logic              o_irq
);

   localparam logic [CNT_W-1:0] LP_WAIT_LAST =
      (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);

   localparam logic [ADDR_W-3:0] LP_W_OUT0   = io_word(IO_OUT0);
   localparam logic [ADDR_W-3:0] LP_W_OUT1   = io_word(IO_OUT1);
   localparam logic [ADDR_W-3:0] LP_W_OUT2   = io_word(IO_OUT2);
   localparam logic [ADDR_W-3:0] LP_W_IN0    = io_word(IO_IN0);
   localparam logic [ADDR_W-3:0] LP_W_IN1    = io_word(IO_IN1);
   localparam logic [ADDR_W-3:0] LP_W_IN2    = io_word(IO_IN2);
   localparam logic [ADDR_W-3:0] LP_W_STATUS = io_word(IO_STATUS);
   localparam logic [ADDR_W-3:0] LP_W_MASK   = io_word(IO_IRQ_MASK);

   io_req_t                 w_req;
   logic [ADDR_W-3:0]       w_word;
   logic [1:0]              r_state;
   logic [1:0]              w_state_nxt;
   logic [CNT_W-1:0]        r_cnt;
   logic [CNT_W-1:0]        w_cnt_nxt;
   logic                    w_commit;
   logic [DATA_W-1:0]       w_rdata;
   logic [NUM_PORTS-1:0]    w_change;
   logic [NUM_PORTS-1:0]    w_clear;
   logic [IN_W-1:0]         w_synced [NUM_PORTS];
   logic [DATA_W-1:0]       r_out [NUM_PORTS];
   logic [NUM_PORTS-1:0]    r_flags;
   logic [DATA_W-1:0]       r_rdata;
   logic                    r_ack;
   logic                    w_unused;

   assign w_req    = '{we: i_we, addr: i_addr, wdata: i_wdata};
   assign w_word   = io_word(w_req.addr);
   assign w_unused = ^w_req.addr[1:0];

   // Three identical input-port synchronizers
   io_in_sync #(.IN_W(IN_W), .SYNC_STAGES(SYNC_STAGES)) u_sync0 (
      .i_clock    (i_clock),
      .i_reset    (i_reset),
      .i_async    (i_in_port0),
      .o_synced   (w_synced[0]),
      .o_change_c (w_change[0])
   );

   io_in_sync #(.IN_W(IN_W), .SYNC_STAGES(SYNC_STAGES)) u_sync1 (
      .i_clock    (i_clock),
      .i_reset    (i_reset),
      .i_async    (i_in_port1),
      .o_synced   (w_synced[1]),
      .o_change_c (w_change[1])
   );

   io_in_sync #(.IN_W(IN_W), .SYNC_STAGES(SYNC_STAGES)) u_sync2 (
      .i_clock    (i_clock),
      .i_reset    (i_reset),
      .i_async    (i_in_port2),
      .o_synced   (w_synced[2]),
      .o_change_c (w_change[2])
   );

   // FSM state and wait counter register
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Next state; w_commit marks the edge that enters RESP (store, read capture, status clear)
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_commit    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_req && w_req.addr[7]) begin
               if (WAIT_CYCLES == 0) begin
                  w_state_nxt = ST_RESP;
                  w_commit    = 1'b1;
               end else begin
                  w_state_nxt = ST_WAIT;
                  w_cnt_nxt   = '0;
               end
            end
         end
         ST_WAIT: begin
            if (!i_req) begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = '0;
            end else if (r_cnt == LP_WAIT_LAST) begin
               w_state_nxt = ST_RESP;
               w_cnt_nxt   = '0;
               w_commit    = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         ST_RESP: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

`ifdef IO_RESP_IRQ_EN
   logic [NUM_PORTS-1:0] r_mask;
   logic                 r_irq;

   // Interrupt mask register and registered interrupt
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_mask <= '0;
         r_irq  <= 1'b0;
      end else begin
         if (w_commit && w_req.we && (w_word == LP_W_MASK)) begin
            r_mask <= w_req.wdata[NUM_PORTS-1:0];
         end
         r_irq <= |(r_flags & r_mask);
      end
   end

   assign o_irq = r_irq;
`else
   assign o_irq = 1'b0;
`endif

   // Load data mux over the register map
   always_comb begin
      w_rdata = '0;
      case (w_word)
         LP_W_OUT0:   w_rdata = r_out[0];
         LP_W_OUT1:   w_rdata = r_out[1];
         LP_W_OUT2:   w_rdata = r_out[2];
         LP_W_IN0:    w_rdata = DATA_W'(w_synced[0]);
         LP_W_IN1:    w_rdata = DATA_W'(w_synced[1]);
         LP_W_IN2:    w_rdata = DATA_W'(w_synced[2]);
         LP_W_STATUS: w_rdata = DATA_W'(r_flags);
`ifdef IO_RESP_IRQ_EN
         LP_W_MASK:   w_rdata = DATA_W'(r_mask);
`else
         LP_W_MASK:   w_rdata = '0;
`endif
         default:     w_rdata = '0;
      endcase
   end

   // A committed STATUS load clears the flags it returned
   assign w_clear = (w_commit && !w_req.we && (w_word == LP_W_STATUS)) ? '1 : '0;

   // Sticky change flags; a new change wins over a simultaneous clear
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_flags <= '0;
      end else begin
         r_flags <= (r_flags & ~w_clear) | w_change;
      end
   end

   // Output ports, ack pulse and load data
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            r_out[p] <= '0;
         end
         r_ack   <= 1'b0;
         r_rdata <= '0;
      end else begin
         r_ack   <= w_commit;
         r_rdata <= (w_commit && !w_req.we) ? w_rdata : '0;
         if (w_commit && w_req.we) begin
            case (w_word)
               LP_W_OUT0: r_out[0] <= w_req.wdata;
               LP_W_OUT1: r_out[1] <= w_req.wdata;
               LP_W_OUT2: r_out[2] <= w_req.wdata;
               default:   ;
            endcase
         end
      end
   end

   assign o_ack       = r_ack;
   assign o_rdata     = r_rdata;
   assign o_out_port0 = r_out[0];
   assign o_out_port1 = r_out[1];
   assign o_out_port2 = r_out[2];

endmodule

// File: tb/tb_io_port_responder.sv
// Self-checking bench for io_port_responder against a register-map level reference model.
// Exercises the IRQ path only when IO_RESP_IRQ_EN is defined.
module tb_io_port_responder;

   localparam int WAITC = 1;

   logic        clk;
   logic        rst;
   logic        req;
   logic        we;
   logic [7:0]  addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        ack;
   logic [3:0]  in0, in1, in2;
   logic [31:0] out0, out1, out2;
   logic        irq;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [31:0] m_out [3];
   logic [3:0]  m_in  [3];
   logic [2:0]  m_flags;
   logic [2:0]  m_mask;

   logic [7:0] addr_tab [10] = '{8'h80, 8'h84, 8'h88, 8'hC0, 8'hC4, 8'hC8, 8'hCC, 8'hD0, 8'hF0, 8'hA4};

   io_port_responder #(.WAIT_CYCLES(WAITC), .IN_W(4), .SYNC_STAGES(2)) dut (
      .i_clock     (clk),
      .i_reset     (rst),
      .i_req       (req),
      .i_we        (we),
      .i_addr      (addr),
      .i_wdata     (wdata),
      .o_rdata     (rdata),
      .o_ack       (ack),
      .i_in_port0  (in0),
      .i_in_port1  (in1),
      .i_in_port2  (in2),
      .o_out_port0 (out0),
      .o_out_port1 (out1),
      .o_out_port2 (out2),
      .o_irq       (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   function automatic logic [31:0] model_read(input logic [7:0] a);
      logic [7:0] w;
      w = {a[7:2], 2'b00};
      case (w)
         8'h80: return m_out[0];
         8'h84: return m_out[1];
         8'h88: return m_out[2];
         8'hC0: return {28'd0, m_in[0]};
         8'hC4: return {28'd0, m_in[1]};
         8'hC8: return {28'd0, m_in[2]};
         8'hCC: return {29'd0, m_flags};
`ifdef IO_RESP_IRQ_EN
         8'hD0: return {29'd0, m_mask};
`endif
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic model_irq();
`ifdef IO_RESP_IRQ_EN
      return |(m_flags & m_mask);
`else
      return 1'b0;
`endif
   endfunction

   task automatic model_access(input logic w, input logic [7:0] a, input logic [31:0] d);
      logic [7:0] wa;
      wa = {a[7:2], 2'b00};
      if (w) begin
         case (wa)
            8'h80: m_out[0] = d;
            8'h84: m_out[1] = d;
            8'h88: m_out[2] = d;
`ifdef IO_RESP_IRQ_EN
            8'hD0: m_mask = d[2:0];
`endif
            default: ;
         endcase
      end else if (wa == 8'hCC) begin
         m_flags = 3'b000;
      end
   endtask

   task automatic model_reset();
      for (int p = 0; p < 3; p++) m_out[p] = 32'd0;
      m_flags = 3'b000;
      m_mask  = 3'b000;
   endtask

   // Change one input port and let it settle through the synchronizer
   task automatic set_in(input int p, input logic [3:0] v);
      @(negedge clk);
      case (p)
         0: in0 = v;
         1: in1 = v;
         default: in2 = v;
      endcase
      if (v != m_in[p]) m_flags[p] = 1'b1;
      m_in[p] = v;
      repeat (5) @(negedge clk);
   endtask

   // One handshake; returns whether ack came within budget, its data and latency in cycles
   task automatic do_xact(input logic w, input logic [7:0] a, input logic [31:0] d, input int budget,
                          output logic got, output logic [31:0] rd, output int lat);
      @(negedge clk);
      req = 1'b1; we = w; addr = a; wdata = d;
      got = 1'b0; rd = 32'd0; lat = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         lat++;
         if (ack === 1'b1) begin
            got = 1'b1;
            rd  = rdata;
            break;
         end
      end
      req = 1'b0;
      if (got) begin
         @(negedge clk);
         checks++;
         if (ack !== 1'b0) begin
            errors++;
            $display("FAIL ack_pulse addr=%h ack=%b required=0", a, ack);
         end
      end
   endtask

   task automatic check_outs(input string tag);
      checks++;
      if (out0 !== m_out[0] || out1 !== m_out[1] || out2 !== m_out[2]) begin
         errors++;
         $display("FAIL %s out_ports got=%h/%h/%h required=%h/%h/%h", tag, out0, out1, out2,
                  m_out[0], m_out[1], m_out[2]);
      end
   endtask

   task automatic check_ack(input string tag, input logic got, input int lat);
      checks++;
      if (got !== 1'b1 || lat != WAITC + 1) begin
         errors++;
         $display("FAIL %s ack got=%b lat=%0d required lat=%0d", tag, got, lat, WAITC + 1);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; req = 1'b0; we = 1'b0; addr = 8'h00; wdata = 32'd0;
      in0 = 4'h0; in1 = 4'h0; in2 = 4'h0;
      for (int p = 0; p < 3; p++) m_in[p] = 4'h0;
      model_reset();
      repeat (3) @(negedge clk);
      checks++;
      if (ack !== 1'b0 || rdata !== 32'd0 || irq !== 1'b0) begin
         errors++;
         $display("FAIL reset ack=%b rdata=%h irq=%b required 0/0/0", ack, rdata, irq);
      end
      check_outs("reset");
      rst = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_store();
      logic got; logic [31:0] rd; int lat;
      do_xact(1'b1, 8'h84, 32'hDEADBEEF, 40, got, rd, lat);
      model_access(1'b1, 8'h84, 32'hDEADBEEF);
      check_ack("store84", got, lat);
      checks++;
      if (out1 !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL store84 out_port1=%h required=deadbeef", out1);
      end
      check_outs("store84");
   endtask

   task automatic test_in_read();
      logic got; logic [31:0] rd; int lat; logic [31:0] exp;
      set_in(2, 4'hA);
      exp = model_read(8'hC8);
      do_xact(1'b0, 8'hC8, 32'd0, 40, got, rd, lat);
      check_ack("load_c8", got, lat);
      checks++;
      if (rd !== exp) begin
         errors++;
         $display("FAIL load_c8 rdata=%h required=%h", rd, exp);
      end
   endtask

   task automatic test_status();
      logic got; logic [31:0] rd; int lat; logic [31:0] exp;
      for (int k = 0; k < 3; k++) begin
         if (k == 1) set_in(0, 4'h5);
         exp = model_read(8'hCC);
         do_xact(1'b0, 8'hCC, 32'd0, 40, got, rd, lat);
         model_access(1'b0, 8'hCC, 32'd0);
         check_ack("status", got, lat);
         checks++;
         if (rd !== exp) begin
            errors++;
            $display("FAIL status_read%0d rdata=%h required=%h", k, rd, exp);
         end
      end
   endtask

   task automatic test_abort();
      int acks = 0;
      @(negedge clk);
      req = 1'b1; we = 1'b1; addr = 8'h80; wdata = $urandom;
      @(negedge clk);
      req = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (ack === 1'b1) acks++;
      end
      checks++;
      if (acks != 0) begin
         errors++;
         $display("FAIL abort ack_count=%0d required=0", acks);
      end
      check_outs("abort");
   endtask

   task automatic test_unmapped();
      logic got; logic [31:0] rd; int lat; logic [31:0] exp;
      do_xact(1'b0, 8'h40, 32'd0, 20, got, rd, lat);
      checks++;
      if (got !== 1'b0) begin
         errors++;
         $display("FAIL low_addr ack=%b required=0", got);
      end
      do_xact(1'b0, 8'hF0, 32'd0, 40, got, rd, lat);
      check_ack("load_f0", got, lat);
      checks++;
      if (rd !== 32'd0) begin
         errors++;
         $display("FAIL load_f0 rdata=%h required=0", rd);
      end
      do_xact(1'b1, 8'hF4, $urandom, 40, got, rd, lat);
      check_ack("store_f4", got, lat);
      check_outs("store_f4");
      exp = model_read(8'hD0);
      do_xact(1'b0, 8'hD0, 32'd0, 40, got, rd, lat);
      check_ack("load_d0", got, lat);
      checks++;
      if (rd !== exp) begin
         errors++;
         $display("FAIL load_d0 rdata=%h required=%h", rd, exp);
      end
   endtask

   task automatic test_random();
      logic got; logic [31:0] rd; int lat; logic [31:0] exp;
      logic w; logic [7:0] a; logic [31:0] d;
      for (int it = 0; it < 80; it++) begin
         if ($urandom_range(0, 5) == 0) begin
            set_in(int'($urandom_range(0, 2)), 4'($urandom));
            checks++;
            if (irq !== model_irq()) begin
               errors++;
               $display("FAIL rand_irq it=%0d irq=%b required=%b", it, irq, model_irq());
            end
         end else begin
            a = addr_tab[$urandom_range(0, 9)] | 8'($urandom_range(0, 3));
            w = 1'($urandom);
            d = $urandom;
            exp = model_read(a);
            do_xact(w, a, d, 40, got, rd, lat);
            model_access(w, a, d);
            check_ack("rand", got, lat);
            if (!w) begin
               checks++;
               if (rd !== exp) begin
                  errors++;
                  $display("FAIL rand_load it=%0d addr=%h rdata=%h required=%h", it, a, rd, exp);
               end
            end
            check_outs("rand");
            checks++;
            if (irq !== model_irq()) begin
               errors++;
               $display("FAIL rand_irq it=%0d irq=%b required=%b", it, irq, model_irq());
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      int n = 0;
      int prev = 0;
      int exp_c;
      @(negedge clk);
      req = 1'b1; we = 1'b0; addr = 8'h80; wdata = 32'd0;
      for (int c = 1; c <= 30 && n < 3; c++) begin
         @(negedge clk);
         if (ack === 1'b1) begin
            exp_c = (n == 0) ? WAITC + 1 : prev + WAITC + 2;
            checks++;
            if (c != exp_c) begin
               errors++;
               $display("FAIL b2b ack%0d cycle=%0d required=%0d", n, c, exp_c);
            end
            checks++;
            if (rdata !== m_out[0]) begin
               errors++;
               $display("FAIL b2b rdata=%h required=%h", rdata, m_out[0]);
            end
            prev = c;
            n++;
         end
      end
      req = 1'b0;
      checks++;
      if (n != 3) begin
         errors++;
         $display("FAIL b2b ack_count=%0d required=3", n);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset_mid();
      logic got; logic [31:0] rd; int lat; logic [31:0] exp;
      @(negedge clk);
      req = 1'b1; we = 1'b1; addr = 8'h88; wdata = $urandom;
      @(negedge clk);
      rst = 1'b1; req = 1'b0;
      model_reset();
      @(negedge clk);
      checks++;
      if (ack !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid ack=%b required=0", ack);
      end
      check_outs("reset_mid");
      @(negedge clk);
      rst = 1'b0;
      for (int p = 0; p < 3; p++) if (m_in[p] != 4'h0) m_flags[p] = 1'b1;
      repeat (5) @(negedge clk);
      exp = model_read(8'hCC);
      do_xact(1'b0, 8'hCC, 32'd0, 40, got, rd, lat);
      model_access(1'b0, 8'hCC, 32'd0);
      check_ack("reset_mid_status", got, lat);
      checks++;
      if (rd !== exp) begin
         errors++;
         $display("FAIL reset_mid_status rdata=%h required=%h", rd, exp);
      end
   endtask

`ifdef IO_RESP_IRQ_EN
   task automatic test_irq();
      logic got; logic [31:0] rd; int lat;
      do_xact(1'b1, 8'hD0, 32'h2, 40, got, rd, lat);
      model_access(1'b1, 8'hD0, 32'h2);
      check_ack("mask_store", got, lat);
      set_in(1, m_in[1] ^ 4'h3);
      checks++;
      if (irq !== 1'b1) begin
         errors++;
         $display("FAIL irq_set irq=%b required=1", irq);
      end
      do_xact(1'b0, 8'hCC, 32'd0, 40, got, rd, lat);
      model_access(1'b0, 8'hCC, 32'd0);
      check_ack("irq_status", got, lat);
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL irq_clear irq=%b required=0", irq);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_store();
      test_in_read();
      test_status();
      test_abort();
      test_unmapped();
      test_back_to_back();
      test_random();
      test_reset_mid();
`ifdef IO_RESP_IRQ_EN
      test_irq();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
